// File: rtl/keypad_scan.sv
// 4x4 key matrix scanner: column strobe, frame debounce, single-press detect
// and a small key-code FIFO with a valid/ready handshake toward the CPU.
//
// state  | meaning
// S_IDLE | no key held; next single-key frame is reported
// S_HELD | a press was reported; waiting for a full release
module keypad_scan #(
   parameter int SCAN_DIV   = 1000,
   parameter int DEBOUNCE   = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [3:0] i_row,
   output logic [3:0] o_col,
   output logic [3:0] o_key,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_pressed,
   output logic       o_multi,
   output logic       o_overflow
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;

   typedef enum logic {S_IDLE, S_HELD} state_t;

   logic [3:0]    row_meta, row_sync, row_hit;
   logic [PW-1:0] presc;
   logic [1:0]    col_idx;
   logic          scan_tc, frame_end, frame_diff;
   logic [15:0]   snapshot, snap_next, prev, debounced;
   logic [3:0]    snap_idx;
   logic [3:0]    stable, stable_next;
   logic          deb_load, fsm_eval;
   state_t        state, state_next;
   logic          push, one_key;
   logic [3:0]    push_code;

   logic [3:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_next;
   logic [CW-1:0] count, count_next;
   logic          pop, full, push_ok;
   logic [3:0]    head_next;

   // Rows are pulled up; invert after synchronizing so a 1 means "pressed".
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         row_meta <= 4'hF;
         row_sync <= 4'hF;
      end else begin
         row_meta <= i_row;
         row_sync <= row_meta;
      end
   end

   assign row_hit   = ~row_sync;
   assign scan_tc   = (presc == PW'(SCAN_DIV - 1));
   assign frame_end = scan_tc && (col_idx == 2'd3);

   // The frame compare sees the column-3 samples taken on the same edge.
   always_comb begin
      snap_next = snapshot;
      snap_idx  = 4'd0;
      if (scan_tc) begin
         for (int r = 0; r < 4; r++) begin
            snap_idx            = {2'(r), col_idx};
            snap_next[snap_idx] = row_hit[r];
         end
      end
   end

   always_comb begin
      stable_next = stable;
      frame_diff  = (snap_next != prev);
      if (frame_end) begin
         if (frame_diff)
            stable_next = 4'd1;
         else if (stable < 4'(DEBOUNCE))
            stable_next = stable + 4'd1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         presc    <= '0;
         col_idx  <= 2'd0;
         o_col    <= 4'b1110;
         snapshot <= '0;
         prev     <= '0;
         stable   <= '0;
         deb_load <= 1'b0;
      end else begin
         snapshot <= snap_next;
         stable   <= stable_next;
         deb_load <= frame_end && (stable_next == 4'(DEBOUNCE));
         if (frame_end && frame_diff)
            prev <= snap_next;
         if (scan_tc) begin
            presc   <= '0;
            col_idx <= col_idx + 2'd1;
            o_col   <= ~(4'b0001 << (col_idx + 2'd1));
         end else begin
            presc <= presc + PW'(1);
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         debounced <= '0;
         o_pressed <= 1'b0;
         o_multi   <= 1'b0;
         fsm_eval  <= 1'b0;
      end else begin
         fsm_eval <= deb_load;
         if (deb_load) begin
            debounced <= prev;
            o_pressed <= |prev;
            o_multi   <= |(prev & (prev - 16'd1));
         end
      end
   end

   assign one_key = (debounced != 16'd0) && ((debounced & (debounced - 16'd1)) == 16'd0);

   always_comb begin
      push_code = 4'd0;
      for (int i = 0; i < 16; i++)
         if (debounced[i]) push_code = 4'(i);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      push       = 1'b0;
      if (fsm_eval) begin
         case (state)
            S_IDLE: if (one_key) begin
               push       = 1'b1;
               state_next = S_HELD;
            end
            S_HELD: if (debounced == 16'd0) state_next = S_IDLE;
            default: state_next = S_IDLE;
         endcase
      end
   end

   assign pop     = o_valid && i_ready;
   assign full    = (count == CW'(FIFO_DEPTH));
   assign push_ok = push && (!full || pop);

   // Head is precomputed so o_key/o_valid can be plain registers.
   always_comb begin
      count_next  = count;
      rd_ptr_next = pop ? rd_ptr + AW'(1) : rd_ptr;
      if (push_ok && !pop)
         count_next = count + CW'(1);
      else if (pop && !push_ok)
         count_next = count - CW'(1);
      if (push_ok && (wr_ptr == rd_ptr_next))
         head_next = push_code;
      else
         head_next = mem[rd_ptr_next];
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 4'd0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         o_valid    <= 1'b0;
         o_key      <= 4'd0;
         o_overflow <= 1'b0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= push_code;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (push && full && !pop)
            o_overflow <= 1'b1;
         rd_ptr  <= rd_ptr_next;
         count   <= count_next;
         o_valid <= (count_next != '0);
         o_key   <= (count_next != '0) ? head_next : 4'd0;
      end
   end

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: key-matrix model, scoreboard of
// expected key codes, and scenario tasks run in sequence.
module tb_keypad_scan;

   localparam int SD    = 4;
   localparam int DB    = 2;
   localparam int FRAME = 4 * SD;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [3:0]  i_row;
   logic [3:0]  o_col;
   logic [3:0]  o_key;
   logic        o_valid;
   logic        i_ready = 1'b0;
   logic        o_pressed;
   logic        o_multi;
   logic        o_overflow;

   logic [15:0] keys = 16'h0;
   logic [3:0]  exp_q[$];
   logic [3:0]  mon_exp;
   int          checks = 0;
   int          errors = 0;

   keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE(DB), .FIFO_DEPTH(4)) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_row      (i_row),
      .o_col      (o_col),
      .o_key      (o_key),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_pressed  (o_pressed),
      .o_multi    (o_multi),
      .o_overflow (o_overflow)
   );

   always #5 i_clk = ~i_clk;

   // Passive matrix: a row is pulled low when any pressed key sits on a driven column.
   always_comb begin
      i_row = 4'hF;
      for (int r = 0; r < 4; r++)
         i_row[r] = ~|(keys[r*4 +: 4] & ~o_col);
   end

   always @(negedge i_clk) begin
      if (!i_rst && o_valid && i_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pop: got key %h, none expected", o_key);
         end else begin
            mon_exp = exp_q.pop_front();
            if (o_key !== mon_exp) begin
               errors++;
               $display("FAIL pop_order: got key %h, expected %h", o_key, mon_exp);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic sync_frame();
      logic [3:0] last;
      bit         found;
      last  = o_col;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(posedge i_clk); #1;
         if (o_col == 4'b1110 && last == 4'b0111) found = 1;
         last = o_col;
      end
      if (!found) begin
         errors++;
         $display("FAIL frame_sync: o_col %b never wrapped to 1110", o_col);
      end
   endtask

   task automatic wait_drain(input int max_cycles);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < max_cycles) begin
         tick(1);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d entries outstanding, expected 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      tick(3);
      checks += 6;
      if (o_col !== 4'b1110) begin errors++; $display("FAIL rst_col: got %b expected 1110", o_col); end
      if (o_valid !== 1'b0)  begin errors++; $display("FAIL rst_valid: got %b expected 0", o_valid); end
      if (o_key !== 4'h0)    begin errors++; $display("FAIL rst_key: got %h expected 0", o_key); end
      if (o_pressed !== 1'b0) begin errors++; $display("FAIL rst_pressed: got %b expected 0", o_pressed); end
      if (o_multi !== 1'b0)  begin errors++; $display("FAIL rst_multi: got %b expected 0", o_multi); end
      if (o_overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b expected 0", o_overflow); end
      @(negedge i_clk);
      i_rst = 1'b0;
   endtask

   task automatic test_scan();
      logic [3:0] exp_col;
      for (int n = 1; n <= 10 * FRAME; n++) begin
         @(posedge i_clk); #1;
         exp_col = ~(4'b0001 << ((n / SD) % 4));
         checks += 3;
         if (o_col !== exp_col) begin
            errors++;
            $display("FAIL scan_col: cycle %0d got %b expected %b", n, o_col, exp_col);
         end
         if (o_valid !== 1'b0) begin errors++; $display("FAIL scan_valid: cycle %0d got %b expected 0", n, o_valid); end
         if (o_pressed !== 1'b0) begin errors++; $display("FAIL scan_pressed: cycle %0d got %b expected 0", n, o_pressed); end
      end
   endtask

   task automatic test_single_key();
      int first;
      first   = 0;
      i_ready = 1'b1;
      sync_frame();
      keys[6] = 1'b1;
      exp_q.push_back(4'h6);
      for (int c = 1; c <= 60 && first == 0; c++) begin
         @(posedge i_clk); #1;
         if (o_valid) first = c;
      end
      checks += 3;
      if (first != 2 * FRAME + 2) begin
         errors++;
         $display("FAIL key6_latency: valid at cycle %0d, expected %0d", first, 2 * FRAME + 2);
      end
      tick(1);
      if (o_valid !== 1'b0) begin errors++; $display("FAIL key6_pulse: valid %b one cycle later, expected 0", o_valid); end
      if (o_pressed !== 1'b1) begin errors++; $display("FAIL key6_pressed: got %b expected 1", o_pressed); end
      sync_frame();
      keys = 16'h0;
      tick(5 * FRAME);
      checks += 2;
      if (o_pressed !== 1'b0) begin errors++; $display("FAIL key6_release: pressed %b expected 0", o_pressed); end
      if (exp_q.size() != 0) begin errors++; $display("FAIL key6_queue: %0d left expected 0", exp_q.size()); end
   endtask

   task automatic test_chatter();
      int seen;
      seen = 0;
      sync_frame();
      for (int t = 1; t <= 52; t++) begin
         if (t == 12 || t == 32) keys[3] = 1'b1;
         if (t == 22 || t == 42) keys[3] = 1'b0;
         @(posedge i_clk); #1;
         if (o_valid) seen++;
      end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL chatter_push: valid seen %0d cycles, expected 0", seen); end
      keys[3] = 1'b1;
      exp_q.push_back(4'h3);
      wait_drain(4 * FRAME);
      tick(2 * FRAME);
      sync_frame();
      keys = 16'h0;
      tick(4 * FRAME);
   endtask

   task automatic test_multi();
      sync_frame();
      keys[0]  = 1'b1;
      keys[15] = 1'b1;
      tick(4 * FRAME);
      checks += 3;
      if (o_multi !== 1'b1) begin errors++; $display("FAIL multi_flag: got %b expected 1", o_multi); end
      if (o_pressed !== 1'b1) begin errors++; $display("FAIL multi_pressed: got %b expected 1", o_pressed); end
      if (o_valid !== 1'b0) begin errors++; $display("FAIL multi_nopush: valid %b expected 0", o_valid); end
      sync_frame();
      keys = 16'h0;
      tick(4 * FRAME);
      checks += 2;
      if (o_multi !== 1'b0) begin errors++; $display("FAIL multi_clear: got %b expected 0", o_multi); end
      if (o_pressed !== 1'b0) begin errors++; $display("FAIL multi_release: got %b expected 0", o_pressed); end
      sync_frame();
      keys[15] = 1'b1;
      exp_q.push_back(4'hF);
      wait_drain(6 * FRAME);
      sync_frame();
      keys = 16'h0;
      tick(4 * FRAME);
   endtask

   task automatic test_overflow();
      i_ready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         if (k == 5) begin
            checks++;
            if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0 with 4 queued", o_overflow); end
         end
         sync_frame();
         keys[k] = 1'b1;
         if (k <= 4) exp_q.push_back(4'(k));
         tick(4 * FRAME);
         sync_frame();
         keys = 16'h0;
         tick(4 * FRAME);
      end
      checks += 3;
      if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", o_overflow); end
      if (o_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b expected 1", o_valid); end
      if (o_key !== 4'h1) begin errors++; $display("FAIL ovf_head: got %h expected 1", o_key); end
      i_ready = 1'b1;
      wait_drain(12);
      tick(1);
      checks += 2;
      if (o_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: valid %b expected 0", o_valid); end
      if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", o_overflow); end
   endtask

   task automatic test_reset_mid();
      int first;
      first   = 0;
      i_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         sync_frame();
         keys[7 + 2 * k] = 1'b1;
         tick(4 * FRAME);
         sync_frame();
         keys = 16'h0;
         tick(4 * FRAME);
      end
      sync_frame();
      keys[10] = 1'b1;
      tick(FRAME + 5);
      i_rst = 1'b1;
      tick(1);
      checks += 4;
      if (o_col !== 4'b1110) begin errors++; $display("FAIL mid_rst_col: got %b expected 1110", o_col); end
      if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", o_valid); end
      if (o_overflow !== 1'b0) begin errors++; $display("FAIL mid_rst_overflow: got %b expected 0", o_overflow); end
      if (o_pressed !== 1'b0) begin errors++; $display("FAIL mid_rst_pressed: got %b expected 0", o_pressed); end
      exp_q.delete();
      exp_q.push_back(4'hA);
      i_ready = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
      for (int c = 1; c <= 80 && first == 0; c++) begin
         @(posedge i_clk); #1;
         if (o_valid) first = c;
      end
      checks++;
      if (first != DB * FRAME + 2) begin
         errors++;
         $display("FAIL mid_rst_rereport: valid at cycle %0d, expected %0d", first, DB * FRAME + 2);
      end
      wait_drain(4);
      keys = 16'h0;
      tick(2 * FRAME);
   endtask

   initial begin
      test_reset();
      test_scan();
      test_single_key();
      test_chatter();
      test_multi();
      test_overflow();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
